// File: rtl/zero_random_scheduler_pkg.sv
// Shared types and helpers for the zero-sharing random scheduler.
package aes128_package;

  localparam int unsigned DEFAULT_BIT_WIDTH = 2;

  typedef logic [DEFAULT_BIT_WIDTH-1:0] rand_word_t;

  // Random elements needed per refresh word; 0 flags an unsupported share count.
  function automatic int unsigned num_zero_words(int unsigned num_shares);
    case (num_shares)
      2:       return 1;
      3:       return 2;
      4, 5:    return num_shares;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/zero_random_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter
  import aes128_package::*;
#(
  parameter int NUM_CLIENTS = 3,
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic [NUM_CLIENTS-1:0] request,
  input  logic [IDX_W-1:0]       pointer,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       index,
  output logic                   valid
);

  always_comb begin
    int c;
    grant = '0;
    index = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      c = int'(pointer) + k;
      if (c >= NUM_CLIENTS) c = c - NUM_CLIENTS;
      if (!valid && request[IDX_W'(c)]) begin
        valid               = 1'b1;
        grant[IDX_W'(c)]    = 1'b1;
        index               = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/zero_random_scheduler.sv
// Buffers random words and hands each one to exactly one requesting client.
// Optional ZERO_SCHED_STALL_COUNT_EN adds a saturating starved-request counter.
module zero_random_scheduler
  import aes128_package::*;
#(
  parameter int NUM_SHARES  = 2,
  parameter int BIT_WIDTH   = 2,
  parameter int NUM_CLIENTS = 3,
  parameter int FIFO_DEPTH  = 4,
  localparam int NUM_NEEDED = int'(num_zero_words(NUM_SHARES)),
  localparam int WORD_W     = ((NUM_NEEDED > 0) ? NUM_NEEDED : 1) * BIT_WIDTH
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic [WORD_W-1:0]      in_rand_data,
  input  logic                   in_rand_valid,
  output logic                   out_rand_ready,
  input  logic [NUM_CLIENTS-1:0] in_request,
  output logic [NUM_CLIENTS-1:0] out_grant,
  output logic [WORD_W-1:0]      out_random,
`ifdef ZERO_SCHED_STALL_COUNT_EN
  output logic [15:0]            out_stall_count,
`endif
  output logic                   out_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  if (NUM_NEEDED == 0) begin : g_bad_shares
    $error("zero_random_scheduler: unsupported NUM_SHARES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("zero_random_scheduler: FIFO_DEPTH must be a power of two >= 2");
  end
  if (NUM_CLIENTS < 2) begin : g_bad_clients
    $error("zero_random_scheduler: NUM_CLIENTS must be >= 2");
  end

  logic [WORD_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [IDX_W-1:0]       rr_ptr, win_idx;
  logic [NUM_CLIENTS-1:0] win_onehot;
  logic                   win_valid, push, pop;

  // Ready looks only at the registered count, so a pop never frees a slot in the same cycle.
  assign out_rand_ready = (count != CNT_W'(FIFO_DEPTH)) && in_reset;
  assign out_empty      = (count == '0);
  assign push           = in_rand_valid && out_rand_ready;
  assign pop            = win_valid && !out_empty;

  rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_arb (
    .request (in_request),
    .pointer (rr_ptr),
    .grant   (win_onehot),
    .index   (win_idx),
    .valid   (win_valid)
  );

  always_ff @(posedge in_clock) begin
    if (push) mem[wr_ptr] <= in_rand_data;
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      out_grant  <= '0;
      out_random <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop) begin
        out_grant  <= win_onehot;
        out_random <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
        rr_ptr     <= (win_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : win_idx + IDX_W'(1);
      end else begin
        out_grant  <= '0;
        out_random <= '0;
      end
    end
  end

`ifdef ZERO_SCHED_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      stall_q <= '0;
    end else if (|in_request && out_empty && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign out_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_zero_random_scheduler.sv
// Directed vector bench for zero_random_scheduler (4-bit words, 3 clients, depth 4).
module tb_zero_random_scheduler;

  logic       in_clock = 1'b0;
  logic       in_reset = 1'b0;
  logic [3:0] in_rand_data = '0;
  logic       in_rand_valid = 1'b0;
  logic       out_rand_ready;
  logic [2:0] in_request = '0;
  logic [2:0] out_grant;
  logic [3:0] out_random;
  logic       out_empty;
`ifdef ZERO_SCHED_STALL_COUNT_EN
  logic [15:0] out_stall_count;
`endif

  int errors = 0;
  int checks = 0;

  zero_random_scheduler #(
    .NUM_SHARES(2), .BIT_WIDTH(4), .NUM_CLIENTS(3), .FIFO_DEPTH(4)
  ) dut (
    .in_clock       (in_clock),
    .in_reset       (in_reset),
    .in_rand_data   (in_rand_data),
    .in_rand_valid  (in_rand_valid),
    .out_rand_ready (out_rand_ready),
    .in_request     (in_request),
    .out_grant      (out_grant),
    .out_random     (out_random),
`ifdef ZERO_SCHED_STALL_COUNT_EN
    .out_stall_count(out_stall_count),
`endif
    .out_empty      (out_empty)
  );

  always #5 in_clock = ~in_clock;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [2:0] r;
    logic [2:0] g;
    logic [3:0] rd;
    logic       e;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] d, input logic [2:0] r,
                     input logic [2:0] g, input logic [3:0] rd, input logic e, input logic rdy);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.g = g; x.rd = rd; x.e = e; x.rdy = rdy;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clock);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [2:0] r);
    in_rand_valid = v;
    in_rand_data  = d;
    in_request    = r;
  endtask

  initial begin
    //  v  data  req    grant  rand  empty ready   (outputs after the edge)
    add(1, 4'h1, 3'b000, 3'b000, 4'h0, 0, 1);
    add(1, 4'h2, 3'b000, 3'b000, 4'h0, 0, 1);
    add(1, 4'h3, 3'b000, 3'b000, 4'h0, 0, 1);
    add(1, 4'h4, 3'b000, 3'b000, 4'h0, 0, 0);
    add(1, 4'h5, 3'b000, 3'b000, 4'h0, 0, 0);
    add(1, 4'h5, 3'b010, 3'b010, 4'h1, 0, 1);
    add(0, 4'h0, 3'b010, 3'b010, 4'h2, 0, 1);
    add(0, 4'h0, 3'b010, 3'b010, 4'h3, 0, 1);
    add(0, 4'h0, 3'b010, 3'b010, 4'h4, 1, 1);
    add(0, 4'h0, 3'b010, 3'b000, 4'h0, 1, 1);
    add(1, 4'h6, 3'b001, 3'b000, 4'h0, 0, 1);
    add(0, 4'h0, 3'b001, 3'b001, 4'h6, 1, 1);
    add(1, 4'h7, 3'b000, 3'b000, 4'h0, 0, 1);
    add(0, 4'h0, 3'b000, 3'b000, 4'h0, 0, 1);
    add(1, 4'h8, 3'b111, 3'b010, 4'h7, 0, 1);
    add(1, 4'h9, 3'b111, 3'b100, 4'h8, 0, 1);
    add(1, 4'hA, 3'b111, 3'b001, 4'h9, 0, 1);
    add(1, 4'hB, 3'b111, 3'b010, 4'hA, 0, 1);
    add(0, 4'h0, 3'b111, 3'b100, 4'hB, 1, 1);
    add(0, 4'h0, 3'b111, 3'b000, 4'h0, 1, 1);
    add(1, 4'hC, 3'b000, 3'b000, 4'h0, 0, 1);
    add(0, 4'h0, 3'b100, 3'b100, 4'hC, 1, 1);
    add(1, 4'hD, 3'b000, 3'b000, 4'h0, 0, 1);
    add(0, 4'h0, 3'b011, 3'b001, 4'hD, 1, 1);

    #3;
    chk("reset grant", 32'(out_grant), 32'h0);
    chk("reset random", 32'(out_random), 32'h0);
    chk("reset empty", 32'(out_empty), 32'h1);
    chk("reset ready", 32'(out_rand_ready), 32'h0);
    step();
    in_reset = 1'b1;
    #1;
    chk("release ready", 32'(out_rand_ready), 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r);
      step();
      chk($sformatf("vec%0d grant", i), 32'(out_grant), 32'(vecs[i].g));
      chk($sformatf("vec%0d random", i), 32'(out_random), 32'(vecs[i].rd));
      chk($sformatf("vec%0d empty", i), 32'(out_empty), 32'(vecs[i].e));
      chk($sformatf("vec%0d ready", i), 32'(out_rand_ready), 32'(vecs[i].rdy));
    end

    // Reset while a grant is on the output and two words remain buffered.
    drive(1, 4'hE, 3'b000); step();
    drive(1, 4'hF, 3'b000); step();
    drive(1, 4'h1, 3'b000); step();
    drive(0, 4'h0, 3'b001); step();
    chk("pre-reset grant", 32'(out_grant), 32'h1);
    chk("pre-reset random", 32'(out_random), 32'hE);
    in_reset = 1'b0;
    #1;
    chk("async grant", 32'(out_grant), 32'h0);
    chk("async random", 32'(out_random), 32'h0);
    chk("async empty", 32'(out_empty), 32'h1);
    chk("async ready", 32'(out_rand_ready), 32'h0);
    #1;
    in_reset = 1'b1;
    drive(0, 4'h0, 3'b111);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-reset%0d grant", i), 32'(out_grant), 32'h0);
      chk($sformatf("post-reset%0d random", i), 32'(out_random), 32'h0);
      chk($sformatf("post-reset%0d empty", i), 32'(out_empty), 32'h1);
    end
    drive(0, 4'h0, 3'b000);

`ifdef ZERO_SCHED_STALL_COUNT_EN
    in_reset = 1'b0;
    #1;
    chk("stall reset", 32'(out_stall_count), 32'h0);
    in_reset = 1'b1;
    drive(0, 4'h0, 3'b101);
    for (int i = 0; i < 10; i++) step();
    drive(0, 4'h0, 3'b000);
    chk("stall ten", 32'(out_stall_count), 32'd10);
    step();
    chk("stall hold", 32'(out_stall_count), 32'd10);
    force dut.stall_q = 16'hFFFD;
    #1;
    release dut.stall_q;
    drive(0, 4'h0, 3'b010);
    for (int i = 0; i < 4; i++) step();
    chk("stall saturate", 32'(out_stall_count), 32'hFFFF);
    drive(0, 4'h0, 3'b000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
